// File: rtl/mux_pkg.sv
// Shared select encoding for the 4-way mux/demux pair.
// SEL_* codes name the source (mux) or destination (demux) of a word.
package mux_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // Priority pointer value after reset: scan starts just above it, at A.
    localparam logic [1:0] LAST_GRANT_RST = SEL_D;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; the pointer register lives
// in the parent.
// Ports:
//   req        - request per source (bit index = select code)
//   last_grant - code of the previous winner; scan starts one above it
//   enable     - gnt is forced to zero when low
//   gnt        - one-hot grant
//   gnt_idx    - code of the winner (valid when any=1)
//   any        - at least one request present
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    input  logic       enable,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = SEL_A;
        found   = 1'b0;
        idx     = '0;
        any     = |req;
        // Offsets 1..4 visit every source once, ending on the
        // previous winner itself; 2-bit addition wraps 11 -> 00.
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (enable && any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux4way_arbiter.sv
// Merges four valid/ready sources onto one registered output channel
// using round-robin arbitration; out_select reports the winning source.
// Ports:
//   clk, reset                  - rising-edge clock, async active-high reset
//   {a,b,c,d}_valid/_data/_ready - source channels
//   out_valid/out_data/out_select - registered merged channel
//   out_ready                   - sink accepts the held word this cycle
module mux4way_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic             c_valid,
    input  logic [WIDTH-1:0] c_data,
    output logic             c_ready,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             d_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_select,
    input  logic             out_ready
);

    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [1:0]       out_select_q, out_select_d;
    logic [1:0]       last_grant_q, last_grant_d;

    logic             load;
    logic             enable;
    logic [3:0]       gnt;
    logic [1:0]       gnt_idx;
    logic             any;
    logic [WIDTH-1:0] win_data;

    // Register is free when empty or being drained on this edge.
    assign load   = !out_valid_q || out_ready;
    // Readys stay low for the whole time reset is asserted.
    assign enable = load && !reset;

    rr_arbiter4 u_arb (
        .req        ({d_valid, c_valid, b_valid, a_valid}),
        .last_grant (last_grant_q),
        .enable     (enable),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    assign a_ready = gnt[SEL_A];
    assign b_ready = gnt[SEL_B];
    assign c_ready = gnt[SEL_C];
    assign d_ready = gnt[SEL_D];

    always_comb begin
        win_data = a_data;
        unique case (gnt_idx)
            SEL_A: win_data = a_data;
            SEL_B: win_data = b_data;
            SEL_C: win_data = c_data;
            SEL_D: win_data = d_data;
            default: win_data = a_data;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_select_d = out_select_q;
        last_grant_d = last_grant_q;
        if (load) begin
            if (any) begin
                out_valid_d  = 1'b1;
                out_data_d   = win_data;
                out_select_d = gnt_idx;
                last_grant_d = gnt_idx;
            end else begin
                // Bubble: payload and select keep their last value.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_select_q <= SEL_A;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_select_q <= out_select_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_select = out_select_q;

endmodule

// File: tb/tb_mux4way_arbiter.sv
// Bench for mux4way_arbiter: directed scenarios then random traffic,
// all checked against a behavioural round-robin model.
module tb_mux4way_arbiter;

    logic       clk;
    logic       reset;
    logic       vld [4];
    logic [7:0] dat [4];
    logic       out_ready;
    logic       a_ready, b_ready, c_ready, d_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_select;
    logic [3:0] rdy;

    int ncmp = 0;
    int nerr = 0;

    // Reference model state
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_sel;
    int         m_last;
    logic [3:0] acc;

    assign rdy = {d_ready, c_ready, b_ready, a_ready};

    mux4way_arbiter #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (vld[0]),
        .a_data     (dat[0]),
        .a_ready    (a_ready),
        .b_valid    (vld[1]),
        .b_data     (dat[1]),
        .b_ready    (b_ready),
        .c_valid    (vld[2]),
        .c_data     (dat[2]),
        .c_ready    (c_ready),
        .d_valid    (vld[3]),
        .d_data     (dat[3]),
        .d_ready    (d_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_select (out_select),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 2'b00;
        m_last  = 3;
        acc     = 4'b0000;
    endfunction

    task automatic set_src(logic [3:0] v);
        for (int i = 0; i < 4; i++) vld[i] = v[i];
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cycle(string tag);
        int w;
        logic [3:0] er;
        #1;
        w = winner();
        er = 4'b0000;
        if ((!m_valid || out_ready) && w >= 0) er[w] = 1'b1;
        chk({tag, ".ready"}, {28'd0, rdy}, {28'd0, er});
        acc = er;
        @(posedge clk);
        if (!m_valid || out_ready) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = dat[w];
                m_sel   = 2'(w);
                m_last  = w;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".data"}, {24'd0, out_data}, {24'd0, m_data});
        chk({tag, ".sel"}, {30'd0, out_select}, {30'd0, m_sel});
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        set_src(4'b1111);
        for (int i = 0; i < 4; i++) dat[i] = 8'(8'h10 + i);
        model_reset();

        // 1: reset with every source valid
        @(negedge clk);
        @(negedge clk);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.sel", {30'd0, out_select}, 32'd0);
        chk("rst.data", {24'd0, out_data}, 32'd0);
        chk("rst.ready", {28'd0, rdy}, 32'd0);
        reset = 1'b0;

        // 2: single requester c, no bubbles
        set_src(4'b0100);
        dat[2] = 8'h3C;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle("single");
            chk("single.c_ready_prev", {31'd0, acc[2]}, 32'd1);
            chk("single.out", {24'd0, out_data}, 32'h3C);
        end

        // 3: round-robin from fresh reset
        do_reset();
        set_src(4'b1111);
        dat[0] = 8'hA0; dat[1] = 8'hB1; dat[2] = 8'hC2; dat[3] = 8'hD3;
        for (int k = 0; k < 5; k++) begin
            cycle("rr");
            chk("rr.order", {30'd0, out_select}, 32'(k % 4));
        end

        // 4: backpressure while holding 55
        set_src(4'b0010);
        dat[1] = 8'h55;
        cycle("bp.load");
        set_src(4'b1111);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("bp.hold");
            chk("bp.held", {24'd0, out_data}, 32'h55);
        end
        out_ready = 1'b1;
        cycle("bp.release");
        chk("bp.next", {30'd0, out_select}, 32'd2);

        // 5: wrap from pointer d, b and d alternate
        set_src(4'b1000);
        cycle("wrap.d");
        set_src(4'b1010);
        cycle("wrap.1");
        chk("wrap.b", {30'd0, out_select}, 32'd1);
        cycle("wrap.2");
        chk("wrap.d2", {30'd0, out_select}, 32'd3);
        cycle("wrap.3");
        chk("wrap.b2", {30'd0, out_select}, 32'd1);

        // 6: async reset while holding a word
        out_ready = 1'b0;
        cycle("mid.hold");
        reset = 1'b1;
        #1;
        chk("mid.valid", {31'd0, out_valid}, 32'd0);
        chk("mid.ready", {28'd0, rdy}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        set_src(4'b1001);
        cycle("mid.after");
        chk("mid.a_first", {30'd0, out_select}, 32'd0);

        // Random traffic; sources hold while valid and not accepted.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(vld[i] && !acc[i])) begin
                    vld[i] = 1'($urandom_range(0, 1));
                    dat[i] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
